// File: rtl/arb4_mux_ctrl_pkg.sv
// Shared constants for the 4-way arbitrated mux controller: FSM encoding,
// default hold limit, hold-counter width and a one-hot helper.
package arb4_mux_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int MAX_HOLD_DEF = 8;
    localparam int CNT_W        = 4;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arb4_mux_ctrl_mux4_1.sv
// Datapath mux cells: mux2_1 and a mux4_1 built from three mux2_1 instances.
module mux2_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module mux4_1 (
    input  logic [3:0] i_d,
    input  logic [1:0] i_sel,
    output logic       o_y
);
    logic w_lo;
    logic w_hi;

    mux2_1 u_lo  (.i_a(i_d[0]), .i_b(i_d[1]), .i_sel(i_sel[0]), .o_y(w_lo));
    mux2_1 u_hi  (.i_a(i_d[2]), .i_b(i_d[3]), .i_sel(i_sel[0]), .o_y(w_hi));
    mux2_1 u_out (.i_a(w_lo),   .i_b(w_hi),   .i_sel(i_sel[1]), .o_y(o_y));
endmodule

// File: rtl/arb4_mux_ctrl_rr_pick4.sv
// Round-robin search: first requester at or after i_ptr (mod 4) that is
// requesting and not masked out by i_excl.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    input  logic [3:0] i_excl,
    output logic       o_found,
    output logic [1:0] o_idx
);
    logic [3:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // Walk from the farthest slot back to ptr so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (w_cand[i_ptr + 2'(k)]) begin
                o_found = 1'b1;
                o_idx   = i_ptr + 2'(k);
            end
        end
    end
endmodule

// File: rtl/arb4_mux_ctrl.sv
// Round-robin arbiter with hold limit driving a mux4_1 datapath; grant,
// select and data outputs are all registered.
module arb4_mux_ctrl
    import arb4_mux_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] select,
    output logic       dout,
    output logic       dout_valid
);
    state_t           r_state, w_state_nx;
    logic [1:0]       r_owner, w_owner_nx;
    logic [1:0]       r_ptr,   w_ptr_nx;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic             r_dout;
    logic             r_dv;

    logic             w_granting;
    logic             w_release;
    logic [1:0]       w_pick_ptr;
    logic [3:0]       w_excl;
    logic             w_found;
    logic [1:0]       w_idx;
    logic [3:0]       w_mux_d;
    logic             w_mux_y;

    assign w_granting = (r_state == ST_GRANT);
    assign w_release  = w_granting &&
                        (!req[r_owner] || r_cnt == CNT_W'(MAX_HOLD - 1));
    // While granting, the search for a successor starts past the owner and skips it.
    assign w_pick_ptr = w_granting ? r_owner + 2'd1 : r_ptr;
    assign w_excl     = w_granting ? onehot4(r_owner) : 4'b0000;

    rr_pick4 u_pick (
        .i_req   (req),
        .i_ptr   (w_pick_ptr),
        .i_excl  (w_excl),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nx = ST_GRANT;
                    w_owner_nx = w_idx;
                    w_cnt_nx   = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nx = r_owner + 2'd1;
                    w_cnt_nx = '0;
                    if (w_found)
                        w_owner_nx = w_idx;
                    else if (!req[r_owner])
                        w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // The mux routes i_d[select] = din[3-select], so select = 3-owner picks din[owner].
    assign w_mux_d = {din[0], din[1], din[2], din[3]};

    mux4_1 u_mux (
        .i_d   (w_mux_d),
        .i_sel (r_sel),
        .o_y   (w_mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt  <= 4'b0000;
            r_sel  <= 2'd0;
            r_dout <= 1'b0;
            r_dv   <= 1'b0;
        end else begin
            r_gnt <= (w_state_nx == ST_GRANT) ? onehot4(w_owner_nx) : 4'b0000;
            if (w_state_nx == ST_GRANT)
                r_sel <= 2'd3 - w_owner_nx;
            if (|r_gnt)
                r_dout <= w_mux_y;
            r_dv <= |r_gnt;
        end
    end

    assign gnt        = r_gnt;
    assign select     = r_sel;
    assign dout       = r_dout;
    assign dout_valid = r_dv;
endmodule

// File: tb/tb_arb4_mux_ctrl.sv
// Scoreboard bench for arb4_mux_ctrl: a behavioural arbiter model pushes the
// expected outputs each edge, a negedge monitor pops and compares.
module tb_arb4_mux_ctrl;
    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] din = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] select;
    logic       dout;
    logic       dout_valid;

    arb4_mux_ctrl #(.MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .select     (select),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       dout;
        logic       dv;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: owner -1 means nobody holds the grant.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    int   m_sel   = 0;
    logic m_dout  = 1'b0;
    logic m_dv    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   prev;
        int   nxt;
        int   c;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_dout = 1'b0; m_dv = 1'b0;
        end else begin
            if (m_owner >= 0) begin
                m_dout = din[m_owner];
                m_dv   = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (m_owner < 0) begin
                nxt = -1;
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (nxt < 0 && req[c]) nxt = c;
                end
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_hold  = 0;
                end
            end else if (!req[m_owner] || m_hold == MH - 1) begin
                prev  = m_owner;
                m_ptr = (prev + 1) % 4;
                nxt   = -1;
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (nxt < 0 && c != prev && req[c]) nxt = c;
                end
                if (nxt >= 0)      m_owner = nxt;
                else if (!req[prev]) m_owner = -1;
                m_hold = 0;
            end else begin
                m_hold++;
            end
            if (m_owner >= 0) m_sel = 3 - m_owner;
        end
        e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.sel  = 2'(m_sel);
        e.dout = m_dout;
        e.dv   = m_dv;
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("gnt",        gnt,        e.gnt);
            chk("select",     select,     e.sel);
            chk("dout_valid", dout_valid, e.dv);
            chk("dout",       dout,       e.dout);
            chk("gnt_onehot", $countones(gnt) <= 1, 1);
        end
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        req = r;
        din = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        #1;
        chk("reset_gnt",    gnt,        0);
        chk("reset_select", select,     0);
        chk("reset_dv",     dout_valid, 0);
        chk("reset_dout",   dout,       0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single requester with data
        repeat (3) cyc(4'b0100, 4'b0100);
        repeat (3) cyc(4'b0000, 4'b0000);

        // rotation: owner drops its request for one cycle
        for (int i = 0; i < 12; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && i % 2 == 0) r[m_owner] = 1'b0;
            cyc(r, 4'($urandom));
        end
        repeat (2) cyc(4'b0000, 4'b0000);

        // timeout between two constant requesters, then a lone holder
        repeat (20) cyc(4'b0011, 4'($urandom));
        repeat (2)  cyc(4'b0000, 4'b0000);
        repeat (20) cyc(4'b1000, 4'($urandom));
        repeat (2)  cyc(4'b0000, 4'b0000);

        // back-to-back handover from owner 2 to owner 3
        repeat (2) cyc(4'b0100, 4'b1111);
        repeat (3) cyc(4'b1011, 4'b1010);
        repeat (2) cyc(4'b0000, 4'b0000);

        // asynchronous reset in the middle of a grant
        repeat (3) cyc(4'b1111, 4'b0101);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_gnt",    gnt,        0);
        chk("midrst_select", select,     0);
        chk("midrst_dv",     dout_valid, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_gnt", gnt, 4'b0001);
        repeat (3) cyc(4'b1111, 4'b0101);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) < 6);
            if (m_owner >= 0 && $urandom_range(0, 7) == 0) r[m_owner] = 1'b0;
            cyc(r, 4'($urandom));
        end

        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb4_mux_ctrl.md
ARB4_MUX_CTRL -- requirements
Module: arb4_mux_ctrl

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 8, max consecutive grant cycles per owner before forced rotation (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  4  per-requester request; bit i = requester i.
REQ-005 SHALL have port: din  input  4  per-requester data bit; bit i = requester i.
REQ-006 SHALL have port: gnt  output  4  one-hot registered grant; all-zero when idle.
REQ-007 SHALL have port: select  output  2  registered mux select driven to the mux4_1 datapath.
REQ-008 SHALL have port: dout  output  1  registered data from the granted requester.
REQ-009 SHALL have port: dout_valid  output  1  high when dout holds data from a granted cycle.

Function
REQ-010 SHALL implement two states: IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-011 SHALL keep a 2-bit round-robin pointer ptr; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE: if req!=0, SHALL grant the first requester in search order on the next edge and enter GRANT; else stay IDLE.
REQ-013 Grant latency SHALL be one cycle: req rising at edge n is visible in gnt after edge n+1.
REQ-014 SHALL keep a 4-bit hold counter, cleared on every new grant and incremented each GRANT cycle.
REQ-015 GRANT release condition: owner req low, or hold counter = MAX_HOLD-1.
REQ-016 On release SHALL set ptr = owner+1 mod 4 and grant the first other requester in search order with req high on the same edge (back-to-back, no idle gap).
REQ-017 On release with no other requester: if owner req still high (timeout), SHALL re-grant owner with counter cleared; else SHALL enter IDLE.
REQ-018 Without release SHALL hold gnt, select and ptr unchanged, even if higher-priority requests arrive.
REQ-019 mux4_1 routes din[3-select]; SHALL drive select = 3 - owner index whenever gnt!=0, and hold the last value in IDLE.
REQ-020 dout SHALL register the mux4_1 output each cycle gnt!=0; dout_valid SHALL equal gnt!=0 delayed one cycle.
REQ-021 dout SHALL hold its last value while dout_valid is low.
REQ-022 gnt SHALL never have more than one bit set in any cycle, including release cycles.
REQ-023 Request deasserted by a non-owner SHALL have no effect on state.

Reset
REQ-024 rst high SHALL immediately force: state=IDLE, gnt=0000, select=00, ptr=0, hold counter=0, dout=0, dout_valid=0.
REQ-025 rst asserted mid-grant SHALL abort the grant with no release-cycle side effects; after rst falls, arbitration restarts from ptr=0.
REQ-026 First grant SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-027 SHALL instantiate the existing mux4_1 cell (built on mux2_1) for the data path; no behavioural mux for din.
REQ-028 SHALL place state encodings (IDLE=0, GRANT=1), MAX_HOLD default and counter width 4 in the shared project constants include file.
REQ-029 SHALL isolate the round-robin search as one sub-module rr_pick4 (inputs req, ptr, exclude mask; outputs found, index).

Verification
REQ-030 Reset: rst=1 mid-grant with req=1111 -> gnt=0000, select=00, dout_valid=0 in the same cycle; after release first gnt=0001.
REQ-031 Single: req=0100, din=0100 from IDLE -> gnt=0100, select=01 one edge later; dout=1, dout_valid=1 the edge after.
REQ-032 Rotation: req=1111 held, owners release by dropping req for one cycle -> grant order 0,1,2,3,0 with no idle gap.
REQ-033 Timeout: MAX_HOLD=8, req=0011 held constant -> gnt=0001 for exactly 8 cycles, then 0010 for 8, then 0001.
REQ-034 Lone timeout: req=1000 held -> gnt stays 1000 continuously, hold counter wraps at 7, gnt never drops.
REQ-035 Back-to-back: owner 2 drops req while req=1011 -> next gnt=1000 (ptr=3), never 0001, no zero cycle on gnt.
